kernel_cpu_cpu_div_cell: RTL and testbench

Multicycle 32-bit integer divider for the kernel CPU. It is the inverse-direction companion to the multiply cell.
- Accepts E-stage operands on a start strobe.
- Runs a radix-2 restoring division.
- Returns quotient or remainder to the M/W stage with a one-cycle done pulse.
- Covers signed and unsigned divide plus remainder; the CPU stalls on busy.

---
 rtl/kernel_cpu_cpu_div_cell.sv | 158 +++++++++++++++
 tb/tb_kernel_cpu_cpu_div_cell.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/kernel_cpu_cpu_div_cell.sv
// Multicycle radix-2 restoring divider (signed/unsigned, quotient or remainder).
// Optional PREP short-cut for trivial operands: define KERNEL_CPU_DIV_EARLY_OUT_EN.
module kernel_cpu_cpu_div_cell #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] E_src1,
   input  logic [WIDTH-1:0] E_src2,
   input  logic             E_div_start,
   input  logic             E_div_signed,
   input  logic             E_div_rem,
   input  logic             M_div_abort,
   output logic [WIDTH-1:0] M_div_result,
   output logic             M_div_done,
   output logic             M_div_busy,
   output logic [2:0]       M_div_state_dbg
);

   // Handshake: E_div_start is a one-cycle request, accepted only in IDLE or DONE
   // while M_div_abort is low; M_div_busy high means requests are dropped, and
   // M_div_done is a one-cycle valid for M_div_result (no backpressure).
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] src1_q, src1_d, src2_q, src2_d;
   logic             signed_q, signed_d, rem_sel_q, rem_sel_d;
   logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
   logic [WIDTH-1:0] dvs_q, dvs_d, rem_q, rem_d, quo_q, quo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic             accept;
   logic [WIDTH-1:0] mag1, mag2, quo_fix, rem_fix;
   logic [WIDTH:0]   shift;
   logic             no_borrow;

   // Magnitudes fit in WIDTH bits as unsigned values, including -2^(WIDTH-1).
   assign mag1 = (signed_q && src1_q[WIDTH-1]) ? (ONE_W + ~src1_q) : src1_q;
   assign mag2 = (signed_q && src2_q[WIDTH-1]) ? (ONE_W + ~src2_q) : src2_q;

   assign shift     = {rem_q, quo_q[WIDTH-1]};
   assign no_borrow = (shift >= {1'b0, dvs_q});

   assign quo_fix = q_neg_q ? (ONE_W + ~quo_q) : quo_q;
   assign rem_fix = r_neg_q ? (ONE_W + ~rem_q) : rem_q;

   assign accept = E_div_start && !M_div_abort &&
                   ((state_q == S_IDLE) || (state_q == S_DONE));

   always_comb begin
      state_d   = state_q;
      src1_d    = src1_q;
      src2_d    = src2_q;
      signed_d  = signed_q;
      rem_sel_d = rem_sel_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      dvs_d     = dvs_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      cnt_d     = cnt_q;
      result_d  = result_q;

      if (accept) begin
         src1_d    = E_src1;
         src2_d    = E_src2;
         signed_d  = E_div_signed;
         rem_sel_d = E_div_rem;
      end

      unique case (state_q)
         S_IDLE: if (accept) state_d = S_PREP;
         S_PREP: begin
            q_neg_d = signed_q & (src1_q[WIDTH-1] ^ src2_q[WIDTH-1]);
            r_neg_d = signed_q & src1_q[WIDTH-1];
            dvs_d   = mag2;
            quo_d   = mag1;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = S_ITER;
`ifdef KERNEL_CPU_DIV_EARLY_OUT_EN
            if (src2_q == '0) begin
               result_d = rem_sel_q ? src1_q : '1;
               state_d  = S_DONE;
            end else if (mag1 < mag2) begin
               result_d = rem_sel_q ? src1_q : '0;
               state_d  = S_DONE;
            end else if (mag2 == ONE_W) begin
               result_d = rem_sel_q ? '0 :
                          ((signed_q & (src1_q[WIDTH-1] ^ src2_q[WIDTH-1])) ? (ONE_W + ~mag1) : mag1);
               state_d  = S_DONE;
            end
`endif
         end
         S_ITER: begin
            rem_d = no_borrow ? (shift[WIDTH-1:0] - dvs_q) : shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], no_borrow};
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) state_d = S_FIX;
         end
         S_FIX: begin
            // Divide by zero bypasses the sign fix entirely.
            if (src2_q == '0) result_d = rem_sel_q ? src1_q : '1;
            else              result_d = rem_sel_q ? rem_fix : quo_fix;
            state_d = S_DONE;
         end
         S_DONE:  state_d = accept ? S_PREP : S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (M_div_abort) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         src1_q    <= '0;
         src2_q    <= '0;
         signed_q  <= 1'b0;
         rem_sel_q <= 1'b0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         dvs_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         src1_q    <= src1_d;
         src2_q    <= src2_d;
         signed_q  <= signed_d;
         rem_sel_q <= rem_sel_d;
         q_neg_q   <= q_neg_d;
         r_neg_q   <= r_neg_d;
         dvs_q     <= dvs_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
      end
   end

   assign M_div_result    = result_q;
   assign M_div_done      = (state_q == S_DONE);
   assign M_div_busy      = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
   assign M_div_state_dbg = state_q;

endmodule

// File: tb/tb_kernel_cpu_cpu_div_cell.sv
// Bench for kernel_cpu_cpu_div_cell: directed + random divides against an arithmetic model.
module tb_kernel_cpu_cpu_div_cell;

   localparam int W = 32;
`ifdef KERNEL_CPU_DIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic          clk, reset_n;
   logic [W-1:0]  E_src1, E_src2;
   logic          E_div_start, E_div_signed, E_div_rem, M_div_abort;
   logic [W-1:0]  M_div_result;
   logic          M_div_done, M_div_busy;
   logic [2:0]    M_div_state_dbg;

   int            checks, failures;
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  last_res;

   kernel_cpu_cpu_div_cell #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n),
      .E_src1(E_src1), .E_src2(E_src2),
      .E_div_start(E_div_start), .E_div_signed(E_div_signed), .E_div_rem(E_div_rem),
      .M_div_abort(M_div_abort),
      .M_div_result(M_div_result), .M_div_done(M_div_done), .M_div_busy(M_div_busy),
      .M_div_state_dbg(M_div_state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // truncating division with the cell's divide-by-zero rule
   function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input bit sgn, input bit rem);
      longint sa, sb, q, r;
      if (b == 0) return rem ? a : {W{1'b1}};
      if (!sgn) return rem ? (a % b) : (a / b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return rem ? W'(r) : W'(q);
   endfunction

   function automatic int ref_latency(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
      longint ma, mb;
      if (!EARLY) return 35;
      ma = sgn ? longint'($signed(a)) : longint'(a);
      mb = sgn ? longint'($signed(b)) : longint'(b);
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
      if (mb == 0 || ma < mb || mb == 1) return 2;
      return 35;
   endfunction

   // driver: called and returns at a negedge; returns in the done cycle
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                         input bit rem, input int stray_cyc);
      int cyc, exp_lat;
      bit busy_ok;
      E_src1 = a; E_src2 = b; E_div_signed = sgn; E_div_rem = rem; E_div_start = 1'b1;
      exp_q.push_back(ref_result(a, b, sgn, rem));
      exp_lat = ref_latency(a, b, sgn);
      @(negedge clk);
      E_div_start = 1'b0;
      cyc = 1;
      busy_ok = 1'b1;
      while (!M_div_done && cyc < 100) begin
         if (!M_div_busy) busy_ok = 1'b0;
         if (cyc == stray_cyc) begin
            E_div_start = 1'b1; E_src1 = $urandom; E_src2 = $urandom; E_div_rem = ~rem;
         end
         @(negedge clk);
         E_div_start = 1'b0;
         cyc++;
      end
      check("done_latency", cyc, exp_lat);
      check("busy_during_op", {31'd0, busy_ok}, 32'd1);
      check("busy_at_done", {31'd0, M_div_busy}, 32'd0);
      if (exp_q.size() > 0) begin
         last_res = exp_q.pop_front();
         check("result", M_div_result, last_res);
      end
   endtask

   task automatic idle_watch(input int n, input logic [W-1:0] exp_res);
      int done_cnt, busy_cnt;
      done_cnt = 0; busy_cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (M_div_done) done_cnt++;
         if (M_div_busy) busy_cnt++;
      end
      check("idle_no_done", done_cnt, 0);
      check("idle_no_busy", busy_cnt, 0);
      check("idle_result_held", M_div_result, exp_res);
   endtask

   // start an op and advance to the given cycle (returns at that negedge)
   task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b, input int upto);
      E_src1 = a; E_src2 = b; E_div_signed = 1'b0; E_div_rem = 1'b0; E_div_start = 1'b1;
      @(negedge clk);
      E_div_start = 1'b0;
      for (int c = 1; c < upto; c++) @(negedge clk);
   endtask

   initial begin
      logic [W-1:0] a, b;
      bit sgn, rem;
      checks = 0; failures = 0; last_res = '0;
      reset_n = 1'b0; E_src1 = '0; E_src2 = '0;
      E_div_start = 1'b0; E_div_signed = 1'b0; E_div_rem = 1'b0; M_div_abort = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_result", M_div_result, '0);
      check("reset_done", {31'd0, M_div_done}, 32'd0);
      check("reset_busy", {31'd0, M_div_busy}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // directed arithmetic, issued back-to-back from each DONE cycle
      run_op(32'd100, 32'd7, 1'b0, 1'b0, 0);
      run_op(32'd100, 32'd7, 1'b0, 1'b1, 0);
      run_op(32'hFFFFFF9C, 32'd7, 1'b1, 1'b0, 0);
      run_op(32'hFFFFFF9C, 32'd7, 1'b1, 1'b1, 0);
      run_op(32'd100, 32'hFFFFFFF9, 1'b1, 1'b0, 0);
      run_op(32'd100, 32'hFFFFFFF9, 1'b1, 1'b1, 0);
      run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 0);
      run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 0);
      run_op(32'h12345678, 32'd0, 1'b0, 1'b0, 0);
      run_op(32'h12345678, 32'd0, 1'b0, 1'b1, 0);
      run_op(32'hF2345678, 32'd0, 1'b1, 1'b1, 0);
      idle_watch(5, last_res);

      // start pulsed while busy is ignored; exactly one done
      run_op(32'hFFFFFFFF, 32'd3, 1'b0, 1'b0, 5);
      idle_watch(40, last_res);

      // abort at cycle 10, then stay idle
      start_and_wait(32'hFFFFFFFF, 32'd3, 10);
      M_div_abort = 1'b1;
      @(negedge clk);
      M_div_abort = 1'b0;
      check("abort_busy", {31'd0, M_div_busy}, 32'd0);
      check("abort_done", {31'd0, M_div_done}, 32'd0);
      idle_watch(40, last_res);

      // abort at cycle 10, restart immediately
      start_and_wait(32'h0000F000, 32'd9, 10);
      M_div_abort = 1'b1;
      E_div_start = 1'b1;
      @(negedge clk);
      M_div_abort = 1'b0;
      E_div_start = 1'b0;
      check("abort_start_busy", {31'd0, M_div_busy}, 32'd0);
      run_op(32'hDEADBEEF, 32'd1234, 1'b0, 1'b1, 0);
      idle_watch(3, last_res);

      // asynchronous reset in cycle 20
      start_and_wait(32'hFFFFFFFF, 32'd5, 20);
      reset_n = 1'b0;
      #1;
      check("areset_result", M_div_result, '0);
      check("areset_done", {31'd0, M_div_done}, 32'd0);
      check("areset_busy", {31'd0, M_div_busy}, 32'd0);
      check("areset_state", {29'd0, M_div_state_dbg}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      exp_q.delete();
      last_res = '0;
      idle_watch(40, last_res);

      // randomized operations against the model
      for (int n = 0; n < 40; n++) begin
         a   = $urandom;
         sgn = 1'($urandom_range(0, 1));
         rem = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0:       b = '0;
            1:       b = 32'd1;
            2:       b = 32'hFFFFFFFF;
            3:       b = W'($urandom_range(2, 1000));
            4:       begin a = W'($urandom_range(0, 50)); b = W'($urandom_range(51, 5000)); end
            default: b = $urandom;
         endcase
         run_op(a, b, sgn, rem, 0);
         if ($urandom_range(0, 1) == 1) idle_watch(1, last_res);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
